// File: rtl/thermostat_ctrl.sv
// rtl/thermostat_ctrl.sv - thermostat setpoint and hysteresis heat/cool control core
// Optional feature macro: THERMO_AUTOREPEAT_EN (button hold auto-repeat, 500-tick delay, 200-tick rate).
module thermostat_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int SET_MIN    = 10,
  parameter int SET_MAX    = 35,
  parameter int SET_INIT   = 22,
  parameter int HYST       = 1,
  parameter int MIN_RUN_MS = 60000,
  parameter int MIN_OFF_MS = 30000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic [7:0] current_temp,
  input  logic       temp_valid,
  output logic [7:0] set_temp,
  output logic       heat_on,
  output logic       cool_on,
  output logic [1:0] ctrl_state
);

  localparam int             TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0]     SMIN      = 8'(SET_MIN);
  localparam logic [7:0]     SMAX      = 8'(SET_MAX);
  localparam logic [7:0]     SINIT     = 8'(SET_INIT);
  localparam logic [8:0]     HYST9     = 9'(HYST);
  localparam logic [16:0]    RUN_LIM   = 17'(MIN_RUN_MS);
  localparam logic [16:0]    OFF_LIM   = 17'(MIN_OFF_MS);
  localparam logic [16:0]    MS_SAT    = 17'h1FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAT = 2'd1,
    S_COOL = 2'd2,
    S_LOCK = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [TW-1:0]  r_tick_cnt;
  logic           w_tick;
  logic           r_up_d;
  logic           r_dn_d;
  logic           w_up_rise;
  logic           w_dn_rise;
  logic           w_rpt_up;
  logic           w_rpt_dn;
  logic           w_step_up;
  logic           w_step_dn;
  logic [7:0]     r_set_temp;
  logic [7:0]     r_cur_temp;
  logic [7:0]     w_cur;
  logic [8:0]     w_cur9;
  logic [8:0]     w_set9;
  logic [8:0]     w_lo;
  logic [8:0]     w_hi;
  logic [16:0]    r_run_ms;
  logic [16:0]    r_off_ms;
  logic           r_heat_on;
  logic           r_cool_on;
  logic           w_heat_next;
  logic           w_cool_next;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Free-running millisecond prescaler
  always_ff @(posedge clk) begin
    if (reset || w_tick) r_tick_cnt <= '0;
    else                 r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // Previous button samples for rise detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_up_d <= 1'b0;
      r_dn_d <= 1'b0;
    end else begin
      r_up_d <= btn_up;
      r_dn_d <= btn_dn;
    end
  end

  assign w_up_rise = btn_up & ~r_up_d;
  assign w_dn_rise = btn_dn & ~r_dn_d;

`ifdef THERMO_AUTOREPEAT_EN
  logic [9:0] r_hold_cnt;
  logic [9:0] w_hold_inc;
  logic       w_hold_one;
  logic       w_rpt;

  assign w_hold_one = btn_up ^ btn_dn;
  assign w_hold_inc = r_hold_cnt + 10'd1;
  assign w_rpt      = w_hold_one & w_tick & ((w_hold_inc == 10'd500) | (w_hold_inc == 10'd700));
  assign w_rpt_up   = w_rpt & btn_up;
  assign w_rpt_dn   = w_rpt & btn_dn;

  // Hold timer in ticks; folds 700 back to 500 so repeats recur every 200 ticks
  always_ff @(posedge clk) begin
    if (reset || !w_hold_one) r_hold_cnt <= '0;
    else if (w_tick)          r_hold_cnt <= (w_hold_inc == 10'd700) ? 10'd500 : w_hold_inc;
  end
`else
  assign w_rpt_up = 1'b0;
  assign w_rpt_dn = 1'b0;
`endif

  assign w_step_up = (w_up_rise & ~w_dn_rise) | w_rpt_up;
  assign w_step_dn = (w_dn_rise & ~w_up_rise) | w_rpt_dn;

  // Saturating setpoint
  always_ff @(posedge clk) begin
    if (reset)                               r_set_temp <= SINIT;
    else if (w_step_up && r_set_temp < SMAX) r_set_temp <= r_set_temp + 8'd1;
    else if (w_step_dn && r_set_temp > SMIN) r_set_temp <= r_set_temp - 8'd1;
  end

  // Latest temperature sample
  always_ff @(posedge clk) begin
    if (reset)           r_cur_temp <= '0;
    else if (temp_valid) r_cur_temp <= current_temp;
  end

  // The FSM only acts on valid cycles, so the fresh sample is used directly then
  assign w_cur  = temp_valid ? current_temp : r_cur_temp;
  assign w_cur9 = {1'b0, w_cur};
  assign w_set9 = {1'b0, r_set_temp};
  assign w_hi   = w_set9 + HYST9;
  assign w_lo   = (w_set9 >= HYST9) ? (w_set9 - HYST9) : 9'd0;

  // Run and lockout timers, cleared on state entry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_ms <= '0;
      r_off_ms <= '0;
    end else begin
      if ((w_state_next == S_HEAT || w_state_next == S_COOL) && w_state_next != r_state)
        r_run_ms <= '0;
      else if ((r_state == S_HEAT || r_state == S_COOL) && w_tick && r_run_ms != MS_SAT)
        r_run_ms <= r_run_ms + 17'd1;
      if (w_state_next == S_LOCK && r_state != S_LOCK)
        r_off_ms <= '0;
      else if (r_state == S_LOCK && w_tick && r_off_ms != MS_SAT)
        r_off_ms <= r_off_ms + 17'd1;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (temp_valid) begin
          if (w_cur9 <= w_lo)      w_state_next = S_HEAT;
          else if (w_cur9 >= w_hi) w_state_next = S_COOL;
        end
      end
      S_HEAT: if (temp_valid && w_cur9 >= w_set9 && r_run_ms >= RUN_LIM) w_state_next = S_LOCK;
      S_COOL: if (temp_valid && w_cur9 <= w_set9 && r_run_ms >= RUN_LIM) w_state_next = S_LOCK;
      S_LOCK: if (w_tick && r_off_ms >= OFF_LIM) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    w_heat_next = (w_state_next == S_HEAT);
    w_cool_next = (w_state_next == S_COOL);
  end

  // State and registered heater/cooler enables
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_heat_on <= 1'b0;
      r_cool_on <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_heat_on <= w_heat_next;
      r_cool_on <= w_cool_next;
    end
  end

  assign set_temp   = r_set_temp;
  assign heat_on    = r_heat_on;
  assign cool_on    = r_cool_on;
  assign ctrl_state = r_state;

endmodule

// File: tb/tb_thermostat_ctrl.sv
// tb/tb_thermostat_ctrl.sv - randomized self-checking bench for thermostat_ctrl
module tb_thermostat_ctrl;

  localparam int TD  = 10;
  localparam int RUN = 5;
  localparam int OFF = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic [7:0] current_temp = 8'd0;
  logic       temp_valid = 1'b0;
  logic [7:0] set_temp;
  logic       heat_on;
  logic       cool_on;
  logic [1:0] ctrl_state;

  int n_cmp = 0;
  int n_err = 0;

  thermostat_ctrl #(
    .TICK_DIV(TD), .SET_MIN(10), .SET_MAX(35), .SET_INIT(22), .HYST(1),
    .MIN_RUN_MS(RUN), .MIN_OFF_MS(OFF)
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn),
    .current_temp(current_temp), .temp_valid(temp_valid),
    .set_temp(set_temp), .heat_on(heat_on), .cool_on(cool_on), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  // Reference model: setpoint arithmetic, elapsed-tick timers, state numbers 0..3
  int m_set, m_state, m_phase, m_run, m_off, m_hold;
  bit m_upp, m_dnp;

  always @(posedge clk) begin : model
    int ns, lo, hi, cur;
    bit tk, ur, dr, rpt, su, sd;
    if (reset) begin
      m_set = 22; m_state = 0; m_phase = 0; m_run = 0; m_off = 0; m_hold = 0;
      m_upp = 0; m_dnp = 0;
    end else begin
      tk = (m_phase == TD - 1);
      m_phase = tk ? 0 : m_phase + 1;
      cur = int'(current_temp);
      lo = (m_set > 1) ? m_set - 1 : 0;
      hi = m_set + 1;
      ns = m_state;
      case (m_state)
        0: if (temp_valid) begin
             if (cur <= lo) ns = 1;
             else if (cur >= hi) ns = 2;
           end
        1: if (temp_valid && cur >= m_set && m_run >= RUN) ns = 3;
        2: if (temp_valid && cur <= m_set && m_run >= RUN) ns = 3;
        default: if (tk && m_off >= OFF) ns = 0;
      endcase
      if (ns != m_state) begin
        if (ns == 1 || ns == 2) m_run = 0;
        if (ns == 3) m_off = 0;
      end else if (tk) begin
        if (m_state == 1 || m_state == 2) m_run++;
        else if (m_state == 3) m_off++;
      end
      m_state = ns;
      ur = btn_up && !m_upp;
      dr = btn_dn && !m_dnp;
      rpt = 0;
`ifdef THERMO_AUTOREPEAT_EN
      if (btn_up != btn_dn) begin
        if (tk) begin
          m_hold++;
          rpt = (m_hold >= 500) && (((m_hold - 500) % 200) == 0);
        end
      end else m_hold = 0;
`endif
      su = (ur && !dr) || (rpt && btn_up);
      sd = (dr && !ur) || (rpt && btn_dn);
      if (su) m_set = (m_set < 35) ? m_set + 1 : 35;
      else if (sd) m_set = (m_set > 10) ? m_set - 1 : 10;
      m_upp = btn_up;
      m_dnp = btn_dn;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; btn_up = 1'b0; btn_dn = 1'b0; temp_valid = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  task automatic send_temp(input int t);
    current_temp = 8'(t); temp_valid = 1'b1;
    step(1);
    temp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    n_cmp++;
    if ({set_temp, ctrl_state, heat_on, cool_on} !== {8'd22, 2'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got set=%0d st=%0d heat=%0b cool=%0b, expected 22 0 0 0",
               set_temp, ctrl_state, heat_on, cool_on);
    end
  endtask

  task automatic test_setpoint();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      btn_up = 1'b1; step(1); btn_up = 1'b0; step(1);
      n_cmp++;
      if (set_temp !== 8'(m_set)) begin
        n_err++;
        $display("FAIL sp_up_%0d: got %0d expected %0d", i, set_temp, m_set);
      end
    end
    n_cmp++;
    if (set_temp !== 8'd35) begin
      n_err++;
      $display("FAIL sp_max: got %0d expected 35", set_temp);
    end
    for (int i = 0; i < 30; i++) begin
      btn_dn = 1'b1; step(1); btn_dn = 1'b0; step(1);
    end
    n_cmp++;
    if (set_temp !== 8'd10) begin
      n_err++;
      $display("FAIL sp_min: got %0d expected 10", set_temp);
    end
    for (int i = 0; i < 2; i++) begin
      btn_up = 1'b1; step(1); btn_up = 1'b0; step(1);
    end
    btn_up = 1'b1; btn_dn = 1'b1; step(1);
    n_cmp++;
    if (set_temp !== 8'd12) begin
      n_err++;
      $display("FAIL sp_both: got %0d expected 12", set_temp);
    end
    btn_up = 1'b0; btn_dn = 1'b0; step(1);
  endtask

  task automatic test_heat();
    do_reset();
    send_temp(21);
    n_cmp++;
    if ({ctrl_state, heat_on, cool_on} !== {2'd1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL heat_enter: got st=%0d heat=%0b cool=%0b expected 1 1 0", ctrl_state, heat_on, cool_on);
    end
    step(29);
    send_temp(22);
    n_cmp++;
    if ({ctrl_state, heat_on} !== {2'd1, 1'b1}) begin
      n_err++;
      $display("FAIL heat_minrun: got st=%0d heat=%0b expected 1 1", ctrl_state, heat_on);
    end
    step(30);
    send_temp(22);
    n_cmp++;
    if ({ctrl_state, heat_on, cool_on} !== {2'd3, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL heat_exit: got st=%0d heat=%0b cool=%0b expected 3 0 0", ctrl_state, heat_on, cool_on);
    end
    step(15);
    n_cmp++;
    if (ctrl_state !== 2'd3) begin
      n_err++;
      $display("FAIL lockout_hold: got st=%0d expected 3", ctrl_state);
    end
    step(30);
    n_cmp++;
    if ({ctrl_state, heat_on, cool_on} !== {2'd0, 1'b0, 1'b0} || ctrl_state !== 2'(m_state)) begin
      n_err++;
      $display("FAIL lockout_exit: got st=%0d heat=%0b cool=%0b expected 0 0 0 (model %0d)",
               ctrl_state, heat_on, cool_on, m_state);
    end
  endtask

  task automatic test_cool();
    do_reset();
    send_temp(23);
    n_cmp++;
    if ({ctrl_state, heat_on, cool_on} !== {2'd2, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL cool_enter: got st=%0d heat=%0b cool=%0b expected 2 0 1", ctrl_state, heat_on, cool_on);
    end
    step(50);
    send_temp(22);
    n_cmp++;
    if ({ctrl_state, cool_on} !== {2'd3, 1'b0}) begin
      n_err++;
      $display("FAIL cool_exit: got st=%0d cool=%0b expected 3 0", ctrl_state, cool_on);
    end
    step(50);
    send_temp(22);
    n_cmp++;
    if ({ctrl_state, heat_on, cool_on} !== {2'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL idle_deadband: got st=%0d heat=%0b cool=%0b expected 0 0 0", ctrl_state, heat_on, cool_on);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_temp(20);
    for (int i = 0; i < 2; i++) begin
      btn_up = 1'b1; step(1); btn_up = 1'b0; step(1);
    end
    n_cmp++;
    if ({set_temp, ctrl_state, heat_on} !== {8'd24, 2'd1, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset: got set=%0d st=%0d heat=%0b expected 24 1 1", set_temp, ctrl_state, heat_on);
    end
    reset = 1'b1;
    step(1);
    n_cmp++;
    if ({set_temp, ctrl_state, heat_on, cool_on} !== {8'd22, 2'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid: got set=%0d st=%0d heat=%0b cool=%0b expected 22 0 0 0",
               set_temp, ctrl_state, heat_on, cool_on);
    end
    reset = 1'b0;
  endtask

  task automatic test_autorepeat();
    int exp_set;
`ifdef THERMO_AUTOREPEAT_EN
    exp_set = 25;
`else
    exp_set = 23;
`endif
    do_reset();
    btn_up = 1'b1;
    step(850 * TD);
    n_cmp++;
    if (set_temp !== 8'(exp_set) || set_temp !== 8'(m_set)) begin
      n_err++;
      $display("FAIL autorepeat: got %0d expected %0d (model %0d)", set_temp, exp_set, m_set);
    end
    btn_up = 1'b0;
    step(1);
  endtask

  task automatic test_random();
    int t;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 7) == 0) btn_dn = ~btn_dn;
      temp_valid = ($urandom_range(0, 3) == 0);
      t = m_set - 3 + int'($urandom_range(0, 6));
      current_temp = 8'(t);
      reset = ($urandom_range(0, 499) == 0);
      step(1);
      n_cmp++;
      if ({set_temp, ctrl_state, heat_on, cool_on} !==
          {8'(m_set), 2'(m_state), m_state == 1, m_state == 2}) begin
        n_err++;
        $display("FAIL random_%0d: got set=%0d st=%0d heat=%0b cool=%0b expected set=%0d st=%0d",
                 i, set_temp, ctrl_state, heat_on, cool_on, m_set, m_state);
      end
    end
    reset = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; temp_valid = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_setpoint();
    test_heat();
    test_cool();
    test_reset_mid();
    test_autorepeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
